// File: rtl/hwpe_stream_tcdm_mem_responder.sv
// Single-port TCDM responder: word-addressed register-file memory with a
// fixed-latency (1 cycle) read path, a free-running grant-throttling pattern,
// granted-transaction counters and a sticky out-of-range flag.
module hwpe_stream_tcdm_mem_responder #(
  parameter int unsigned NB_WORDS     = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_valid_o,
  output logic        err_o,
  output logic [31:0] nb_reads_o,
  output logic [31:0] nb_writes_o
);

  localparam int unsigned AW          = (NB_WORDS > 32'd1) ? $clog2(NB_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES  = 32'(NB_WORDS) << 2;
  localparam logic [31:0] STALL_START = 32'(STALL_PERIOD - STALL_CYCLES);
  localparam logic [31:0] STALL_LAST  = (STALL_PERIOD == 32'd0) ? 32'd0 : 32'(STALL_PERIOD - 32'd1);

  // Merge new write data into an existing word under a byte-enable mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]   mem_r [NB_WORDS];
  logic [31:0]   stall_cnt_r;
  logic [31:0]   r_data_r;
  logic          r_valid_r;
  logic          err_r;
  logic [31:0]   nb_reads_r;
  logic [31:0]   nb_writes_r;

  logic          stall_s;
  logic          gnt_s;
  logic          rd_hs_s;
  logic          wr_hs_s;
  logic [31:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;

  // Throttle decision, grant and address decode.
  always_comb begin
    stall_s    = 1'b0;
    gnt_s      = 1'b0;
    off_s      = 32'd0;
    in_range_s = 1'b0;
    idx_s      = '0;
    if (STALL_PERIOD != 32'd0) begin
      stall_s = (stall_cnt_r >= STALL_START);
    end else begin
      stall_s = 1'b0;
    end
    // A request coinciding with clear is never granted, so it has no side effects.
    gnt_s      = tcdm_req_i & ~stall_s & ~clear_i;
    off_s      = tcdm_add_i - BASE_ADDR;
    in_range_s = (off_s < SPAN_BYTES);
    idx_s      = off_s[AW+1:2];
  end

  assign rd_hs_s = gnt_s &  tcdm_wen_i;
  assign wr_hs_s = gnt_s & ~tcdm_wen_i;

  // Free-running throttle counter, independent of request activity.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      stall_cnt_r <= 32'd0;
    end else if (STALL_PERIOD == 32'd0) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_cnt_r == STALL_LAST) begin
      stall_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  // Memory array: not cleared by reset; out-of-range writes are discarded.
  always_ff @(posedge clk_i) begin
    if (wr_hs_s && in_range_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], tcdm_data_i, tcdm_be_i);
    end
  end

  // Read response: one-cycle latency, data held between responses.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_valid_r <= 1'b0;
      r_data_r  <= 32'd0;
    end else begin
      r_valid_r <= rd_hs_s;
      if (rd_hs_s) begin
        r_data_r <= in_range_s ? mem_r[idx_s] : 32'd0;
      end
    end
  end

  // Sticky out-of-range flag, set by any granted access outside the window.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      err_r <= 1'b0;
    end else if (gnt_s && !in_range_s) begin
      err_r <= 1'b1;
    end
  end

  // Granted-transaction counters, wrapping silently.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      nb_reads_r  <= 32'd0;
      nb_writes_r <= 32'd0;
    end else begin
      if (rd_hs_s) begin
        nb_reads_r <= nb_reads_r + 32'd1;
      end
      if (wr_hs_s) begin
        nb_writes_r <= nb_writes_r + 32'd1;
      end
    end
  end

  assign tcdm_gnt_o     = gnt_s;
  assign tcdm_r_data_o  = r_data_r;
  assign tcdm_r_valid_o = r_valid_r;
  assign err_o          = err_r;
  assign nb_reads_o     = nb_reads_r;
  assign nb_writes_o    = nb_writes_r;

endmodule

// File: tb/tb_hwpe_stream_tcdm_mem_responder.sv
// Scoreboard bench: instance A (no throttling, non-zero base) is driven with
// directed transactions whose read responses are queued and checked by a
// monitor; instance B (period 4, 1 stall cycle) checks the grant pattern.
module tb_hwpe_stream_tcdm_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Instance A signals
  logic        a_clear, a_req, a_gnt, a_wen, a_r_valid, a_err;
  logic [31:0] a_add, a_data, a_r_data, a_nb_reads, a_nb_writes;
  logic [3:0]  a_be;
  // Instance B signals
  logic        b_clear, b_req, b_gnt, b_wen, b_r_valid, b_err;
  logic [31:0] b_add, b_data, b_r_data, b_nb_reads, b_nb_writes;
  logic [3:0]  b_be;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;
  rd_t rd_q[$];
  rd_t mon_e;

  int exp_rd = 0;
  int exp_wr = 0;
  int b_hs = 0;
  int b_rv_cnt = 0;
  logic [15:0] b_gnt_pat;

  hwpe_stream_tcdm_mem_responder #(
    .NB_WORDS(256), .BASE_ADDR(BASE), .STALL_PERIOD(0), .STALL_CYCLES(0)
  ) dut_a (
    .clk_i(clk), .clear_i(a_clear), .tcdm_req_i(a_req), .tcdm_gnt_o(a_gnt),
    .tcdm_add_i(a_add), .tcdm_wen_i(a_wen), .tcdm_be_i(a_be), .tcdm_data_i(a_data),
    .tcdm_r_data_o(a_r_data), .tcdm_r_valid_o(a_r_valid), .err_o(a_err),
    .nb_reads_o(a_nb_reads), .nb_writes_o(a_nb_writes)
  );

  hwpe_stream_tcdm_mem_responder #(
    .NB_WORDS(16), .BASE_ADDR(32'h0000_0000), .STALL_PERIOD(4), .STALL_CYCLES(1)
  ) dut_b (
    .clk_i(clk), .clear_i(b_clear), .tcdm_req_i(b_req), .tcdm_gnt_o(b_gnt),
    .tcdm_add_i(b_add), .tcdm_wen_i(b_wen), .tcdm_be_i(b_be), .tcdm_data_i(b_data),
    .tcdm_r_data_o(b_r_data), .tcdm_r_valid_o(b_r_valid), .err_o(b_err),
    .nb_reads_o(b_nb_reads), .nb_writes_o(b_nb_writes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for instance A read responses.
  always @(negedge clk) begin
    if (a_r_valid === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: cycle %0d data %h, no read pending", cyc, a_r_data);
      end else begin
        mon_e = rd_q.pop_front();
        if (a_r_data !== mon_e.data || cyc != mon_e.cyc + 1) begin
          errors++;
          $display("FAIL read_resp: got data %h at cycle %0d, expected %h at cycle %0d",
                   a_r_data, cyc, mon_e.data, mon_e.cyc + 1);
        end
      end
    end else if (rd_q.size() != 0 && cyc > rd_q[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid: cycle %0d, expected data %h", cyc, rd_q[0].data);
      mon_e = rd_q.pop_front();
    end
  end

  // Response counter for instance B.
  always @(negedge clk) begin
    if (b_r_valid === 1'b1) b_rv_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One transaction on A; called just after a rising edge, returns likewise.
  task automatic a_xfer(input logic [31:0] add, input logic wen, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] exp);
    a_add = add; a_wen = wen; a_be = be; a_data = data; a_req = 1'b1;
    @(negedge clk);
    chk("gnt_same_cycle", {31'd0, a_gnt}, 32'd1);
    if (a_gnt === 1'b1) begin
      if (wen) begin
        rd_q.push_back('{data: exp, cyc: cyc});
        exp_rd++;
      end else begin
        exp_wr++;
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_nb_reads"},  a_nb_reads,  32'(exp_rd));
    chk({tag, "_nb_writes"}, a_nb_writes, 32'(exp_wr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_clear = 1'b1; a_req = 1'b0; a_add = 32'd0; a_wen = 1'b0; a_be = 4'h0; a_data = 32'd0;
    b_clear = 1'b1; b_req = 1'b0; b_add = 32'd0; b_wen = 1'b0; b_be = 4'h0; b_data = 32'd0;
    b_gnt_pat = 16'h7777;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r_valid",   {31'd0, a_r_valid}, 32'd0);
    chk("rst_r_data",    a_r_data,    32'd0);
    chk("rst_err",       {31'd0, a_err}, 32'd0);
    chk("rst_nb_reads",  a_nb_reads,  32'd0);
    chk("rst_nb_writes", a_nb_writes, 32'd0);
    @(posedge clk); #1;
    a_clear = 1'b0;

    // Basic write then read of the same word
    a_xfer(BASE + 32'd8, 1'b0, 4'hF, 32'hCAFE_F00D, 32'd0);
    a_xfer(BASE + 32'd8, 1'b1, 4'hF, 32'd0, 32'hCAFE_F00D);
    idle(2);
    chk("basic_nb_writes", a_nb_writes, 32'd1);
    chk("basic_nb_reads",  a_nb_reads,  32'd1);

    // Byte enables; low address bits ignored; be=0 is a no-op write
    a_xfer(BASE + 32'd12, 1'b0, 4'hF,    32'h1122_3344, 32'd0);
    a_xfer(BASE + 32'd12, 1'b0, 4'b0101, 32'hAABB_CCDD, 32'd0);
    a_xfer(BASE + 32'd15, 1'b1, 4'hF,    32'd0, 32'h11BB_33DD);
    a_xfer(BASE + 32'd12, 1'b0, 4'h0,    32'hFFFF_FFFF, 32'd0);
    a_xfer(BASE + 32'd12, 1'b1, 4'h0,    32'd0, 32'h11BB_33DD);
    idle(2);
    chk_cnt("be");

    // Back-to-back reads of preloaded words 0..7
    for (int i = 0; i < 8; i++) a_xfer(BASE + 32'(4 * i), 1'b0, 4'hF, 32'(i), 32'd0);
    for (int i = 0; i < 8; i++) a_xfer(BASE + 32'(4 * i), 1'b1, 4'h0, 32'd0, 32'(i));
    idle(2);
    chk("rdata_hold_valid", {31'd0, a_r_valid}, 32'd0);
    chk("rdata_hold_data",  a_r_data, 32'd7);
    chk_cnt("b2b");

    // Out-of-range accesses above and below the window
    chk("err_before_oor", {31'd0, a_err}, 32'd0);
    a_xfer(BASE + 32'h400, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'd0);
    chk("err_set", {31'd0, a_err}, 32'd1);
    a_xfer(BASE + 32'h400, 1'b1, 4'hF, 32'd0, 32'd0);
    a_xfer(BASE,           1'b1, 4'hF, 32'd0, 32'd0);
    a_xfer(BASE - 32'd4,   1'b1, 4'hF, 32'd0, 32'd0);
    idle(3);
    chk("err_sticky", {31'd0, a_err}, 32'd1);
    chk_cnt("oor");
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    exp_rd = 0; exp_wr = 0;
    chk("err_cleared", {31'd0, a_err}, 32'd0);
    chk_cnt("oor_clr");

    // Clear in the cycle after a read handshake
    a_xfer(BASE + 32'd20, 1'b0, 4'hF, 32'h5555_AAAA, 32'd0);
    a_xfer(BASE + 32'd20, 1'b1, 4'hF, 32'd0, 32'h5555_AAAA);
    a_clear = 1'b1; a_req = 1'b1; a_wen = 1'b0; a_add = BASE + 32'd20; a_be = 4'hF; a_data = 32'd0;
    @(negedge clk);
    chk("gnt_during_clear", {31'd0, a_gnt}, 32'd0);
    @(posedge clk); #1;
    a_clear = 1'b0; a_req = 1'b0;
    exp_rd = 0; exp_wr = 0;
    chk("clr_r_valid", {31'd0, a_r_valid}, 32'd0);
    chk_cnt("clr");
    a_xfer(BASE + 32'd20, 1'b1, 4'hF, 32'd0, 32'h5555_AAAA);
    idle(3);
    chk("scoreboard_empty", 32'(rd_q.size()), 32'd0);

    // Throttled instance: req held for 16 cycles after reset
    b_clear = 1'b1;
    @(posedge clk); #1;
    b_clear = 1'b0; b_req = 1'b1; b_wen = 1'b1; b_add = 32'd0; b_be = 4'hF;
    b_rv_cnt = 0; b_hs = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (b_gnt !== b_gnt_pat[k]) begin
        errors++;
        $display("FAIL throttle_gnt cycle %0d: got %b expected %b", k, b_gnt, b_gnt_pat[k]);
      end
      if (b_gnt === 1'b1) b_hs++;
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("throttle_handshakes", 32'(b_hs), 32'd12);
    chk("throttle_rvalid_cnt", 32'(b_rv_cnt), 32'd12);
    chk("throttle_nb_reads",   b_nb_reads, 32'd12);
    chk("throttle_err",        {31'd0, b_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_mem_responder.md
Name: hwpe_stream_tcdm_mem_responder

Overview:
- Single-port TCDM responder: the memory-side end of the TCDM protocol, answering requests from the TCDM master ports of HWPE streamers.
- Holds a word-addressed register-file memory and applies a deterministic grant-throttling pattern, so that master-side stall handling can be exercised.
- Counts granted transactions and flags out-of-range accesses.
- Used as the memory model in block-level benches and as a small scratchpad in standalone HWPE integrations.

Parameters:
- NB_WORDS, 256, memory depth in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned.
- STALL_PERIOD, 0, length of the throttling pattern in cycles; 0 disables throttling.
- STALL_CYCLES, 0, grant-low cycles per period; must be less than STALL_PERIOD when STALL_PERIOD is not 0.

Ports:
- clk_i  in  1  clock.
- clear_i  in  1  synchronous active-high reset.
- tcdm_req_i  in  1  request.
- tcdm_gnt_o  out  1  grant.
- tcdm_add_i  in  32  byte address.
- tcdm_wen_i  in  1  1 = read, 0 = write.
- tcdm_be_i  in  4  byte enables, bit i covers data[8i+7:8i].
- tcdm_data_i  in  32  write data.
- tcdm_r_data_o  out  32  read data.
- tcdm_r_valid_o  out  1  read response valid.
- err_o  out  1  sticky out-of-range flag.
- nb_reads_o  out  32  count of granted reads.
- nb_writes_o  out  32  count of granted writes.

Behaviour:
- Reset: all outputs and registers are synchronous on clk_i and take their reset values on the first edge with clear_i=1.
  - tcdm_r_valid_o=0, tcdm_r_data_o=0, err_o=0, nb_reads_o=0, nb_writes_o=0.
  - Stall counter = 0.
  - Memory contents are NOT cleared.
  - clear_i mid-operation drops a read response that is pending for the next cycle. A request presented in the same cycle as clear_i is not granted, causes no write and increments no counter.
- Stall counter:
  - Free-running, 0 to STALL_PERIOD-1, wraps to 0; it runs regardless of tcdm_req_i.
  - stall = (STALL_PERIOD!=0) && (cnt >= STALL_PERIOD-STALL_CYCLES).
  - When STALL_PERIOD=0, stall is constantly 0.
- Grant:
  - tcdm_gnt_o = tcdm_req_i & ~stall & ~clear_i, purely combinational.
  - Handshake = req & gnt. No request is queued; the master holds req and the request fields until granted.
- Address decode:
  - off = tcdm_add_i - BASE_ADDR, 32-bit modular.
  - in_range = off < 4*NB_WORDS.
  - idx = off[log2(NB_WORDS)+1:2]; tcdm_add_i[1:0] is ignored.
- Write handshake (wen=0):
  - When in range, each byte with be[i]=1 is updated at the next edge; bytes with be[i]=0 are unchanged.
  - be=0 is a granted no-op write.
  - nb_writes_o increments.
  - Writes produce no r_valid.
- Read handshake (wen=1):
  - In the next cycle, tcdm_r_valid_o=1 for exactly one cycle and tcdm_r_data_o = mem[idx]; be is ignored.
  - Latency is exactly 1, so every granted read gets its response on the following cycle (zero-latency TCDM rule).
  - nb_reads_o increments.
- Back-to-back: reads granted in consecutive cycles give r_valid high continuously, with one word per cycle in order.
- Read data hold: tcdm_r_data_o holds its last value while r_valid=0.
- Write then read: a write at cycle N followed by a read of the same word at N+1 returns the new data at N+2.
- Out of range:
  - The request is still granted and counted.
  - A write leaves memory untouched.
  - A read returns r_data=0, still with r_valid=1.
  - err_o is set at the next edge and stays set until clear_i.
- Counters wrap from 2^32-1 to 0 with no flag.

Test Plan:
- Write/read with throttling off: write 32'hCAFE_F00D to BASE_ADDR+8 with be=4'hF, then read BASE_ADDR+8.
  - gnt is seen the same cycle as req for both.
  - r_valid=1 exactly 1 cycle after the read handshake, with r_data=32'hCAFE_F00D.
  - nb_writes_o=1, nb_reads_o=1.
- Byte enables: word 3 = 32'h1122_3344, then write 32'hAABB_CCDD with be=4'b0101, then read word 3 -> 32'h11BB_33DD.
- Throttling with STALL_PERIOD=4, STALL_CYCLES=1: hold req=1 for 16 cycles after reset.
  - gnt is low at cycles 3, 7, 11 and 15 only.
  - 12 handshakes; the r_valid count equals the read handshake count.
- Back-to-back reads of words 0..7 preloaded with values 0..7: r_valid is high for 8 consecutive cycles, r_data = 0..7 in order, 1-cycle latency.
- Out of range with NB_WORDS=256: write to BASE_ADDR+32'h400, then read it.
  - Both are granted; memory is unchanged; r_data=0.
  - err_o=1 and stays 1 until clear_i, which returns it to 0.
- Reset mid-read: assert clear_i in the cycle after a read handshake.
  - r_valid=0 in the following cycle; counters = 0.
  - A subsequent read returns the pre-reset data.
